// File: rtl/cla_pipe_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined CLA adder/subtractor.
// Holds the operation encoding and the geometry checks used by cla_pipe_addsub.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int blocks_per_stage(input int width, input int block_w, input int stages);
    return width / block_w / stages;
  endfunction

  function automatic bit width_ok(input int width, input int block_w);
    return (block_w > 0) && (width > 0) && ((width % block_w) == 0);
  endfunction

  function automatic bit stages_ok(input int width, input int block_w, input int stages);
    return (stages > 0) && (block_w > 0) && (((width / block_w) % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master = producer of operands and consumer of results; slave = the adder.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             of;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, of, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, of, zero
  );

endinterface

// File: rtl/cla_pipe_addsub_block.sv
// Combinational BLOCK_W-bit carry-lookahead block: every internal carry is
// expanded straight from bit generate/propagate and cin, plus group g/p out.
module cla_block #(
  parameter int BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] sum,
  output logic               cout,
  output logic               g,
  output logic               p
);

  logic [BLOCK_W-1:0] gb;
  logic [BLOCK_W-1:0] pb;
  logic [BLOCK_W:0]   c;
  logic               acc;
  logic               pchain;

  always_comb begin
    gb     = a & b;
    pb     = a ^ b;
    c      = '0;
    acc    = 1'b0;
    pchain = 1'b1;
    c[0]   = cin;
    for (int i = 0; i < BLOCK_W; i++) begin
      // Sum-of-products carry: c[i+1] never waits on c[i]
      acc    = gb[i];
      pchain = pb[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc    = acc | (pchain & gb[j]);
        pchain = pchain & pb[j];
      end
      c[i+1] = acc | (pchain & cin);
    end
    g    = acc;
    p    = pchain;
    sum  = pb ^ c[BLOCK_W-1:0];
    cout = c[BLOCK_W];
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with global-stall valid/ready flow.
// Define CLA_PIPE_SAT_EN to clamp the sum to the signed range on overflow.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int BLOCK_W = 4,
  parameter int STAGES  = 2
) (
  input logic              clk,
  input logic              rst,
  cla_pipe_addsub_if.slave bus
);

  localparam int NB  = WIDTH / BLOCK_W;
  localparam int BPS = blocks_per_stage(WIDTH, BLOCK_W, STAGES);
  localparam int SW  = BPS * BLOCK_W;
  localparam int MSB = WIDTH - 1;

  if (!width_ok(WIDTH, BLOCK_W) || !stages_ok(WIDTH, BLOCK_W, STAGES)) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must split into BLOCK_W blocks evenly shared by STAGES");
  end

`ifdef CLA_PIPE_SAT_EN
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                                input logic ovf, input logic a_msb);
    if (!ovf) return raw;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  op_e              op;
  logic             adv;

  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_d [STAGES];
  logic             c_q [STAGES];
  logic             vld_d [STAGES];
  logic             vld_q [STAGES];

  logic [WIDTH-1:0]  blk_sum;
  logic [STAGES-1:0] stg_co;

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             of_d, of_q;
  logic             zero_d, zero_q;

  // Stage inputs: stage 0 from the bus, later stages from the previous register
  always_comb begin
    op      = op_e'(bus.sub);
    adv     = bus.out_ready || !vld_q[STAGES-1];
    st_a[0] = bus.a;
    st_b[0] = (op == OP_SUB) ? ~bus.b : bus.b;
    st_s[0] = '0;
    st_c[0] = bus.cin ^ bus.sub;
    st_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = vld_q[k-1];
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int K = i / BPS;
    localparam int J = i % BPS;

    logic               ci;
    logic               co;
    logic               g;
    logic               p;
    logic               gp_unused;
    logic [BLOCK_W-1:0] s;

    if (J == 0) begin : g_head
      assign ci = st_c[K];
    end else begin : g_link
      assign ci = g_blk[i-1].co;
    end

    cla_block #(.BLOCK_W(BLOCK_W)) u_cla (
      .a    (st_a[K][i*BLOCK_W +: BLOCK_W]),
      .b    (st_b[K][i*BLOCK_W +: BLOCK_W]),
      .cin  (ci),
      .sum  (s),
      .cout (co),
      .g    (g),
      .p    (p)
    );

    assign blk_sum[i*BLOCK_W +: BLOCK_W] = s;
    assign gp_unused = g ^ p;

    if (J == BPS - 1) begin : g_tail
      assign stg_co[K] = co;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = st_v[k];
      a_d[k]   = st_a[k];
      b_d[k]   = st_b[k];
      s_d[k]   = st_s[k];
      s_d[k][k*SW +: SW] = blk_sum[k*SW +: SW];
      c_d[k]   = stg_co[k];
    end
    raw_sum = s_d[STAGES-1];
    cout_d  = c_d[STAGES-1];
    of_d    = (a_d[STAGES-1][MSB] == b_d[STAGES-1][MSB]) &&
              (raw_sum[MSB] != a_d[STAGES-1][MSB]);
`ifdef CLA_PIPE_SAT_EN
    sum_d   = sat_sum(raw_sum, of_d, a_d[STAGES-1][MSB]);
`else
    sum_d   = raw_sum;
`endif
    zero_d  = (sum_d == '0);
  end

  // Control and visible outputs: cleared by reset, frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) vld_q[k] <= vld_d[k];
      sum_q  <= sum_d;
      cout_q <= cout_d;
      of_q   <= of_d;
      zero_q <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.of        = of_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=32, BLOCK_W=4, STAGES=2);
// expected sums follow CLA_PIPE_SAT_EN when the build defines it.
module tb_cla_pipe_addsub;

  localparam int W = 32;

`ifdef CLA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_addsub_if #(.WIDTH(W)) bus ();

  cla_pipe_addsub #(.WIDTH(W), .BLOCK_W(4), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] esum,
                          input logic ecout, input logic eof, input logic ezero);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.out_ready = 1'b1;
    #1;
    chk1({tag, ".in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1({tag, ".early"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chk1({tag, ".valid"}, bus.out_valid, 1'b1);
    chk ({tag, ".sum"},   bus.sum,  esum);
    chk1({tag, ".cout"},  bus.cout, ecout);
    chk1({tag, ".of"},    bus.of,   eof);
    chk1({tag, ".zero"},  bus.zero, ezero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got;
    int          sent;
    int          stalls;
    int          quiet;
    logic        held_valid;
    logic [W-1:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst.out_valid", bus.out_valid, 1'b0);
    chk ("rst.sum",       bus.sum,       32'h0);
    chk1("rst.cout",      bus.cout,      1'b0);
    chk1("rst.of",        bus.of,        1'b0);
    chk1("rst.zero",      bus.zero,      1'b0);
    chk1("rst.in_ready",  bus.in_ready,  1'b1);

    op_check("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_check("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    op_check("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_check("sub_pos", 32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    op_check("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
             SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    op_check("sub_borrow", 32'h7, 32'h5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    op_check("add_cin_mid", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    op_check("add_cin_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    op_check("add_mix", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
    op_check("sub_eq", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: six back-to-back adds, consumer stalls in cycles 3..6
    got        = 0;
    sent       = 0;
    stalls     = 0;
    held_valid = 1'b0;
    held       = '0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (held_valid) begin
        chk1("bp.hold_valid", bus.out_valid, 1'b1);
        chk ("bp.hold_sum",   bus.sum,       held);
      end
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (sent < 6);
      bus.a         = sent + 1;
      bus.b         = sent + 1;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk1("bp.full_in_ready", bus.in_ready, 1'b0);
        stalls++;
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held       = bus.sum;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp.sum", bus.sum, 2 * (got + 1));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    chk("bp.count",  got,    32'd6);
    chk("bp.stalls", stalls, 32'd4);

    // Reset while two operations are in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd100;
    bus.b         = 32'd1;
    @(negedge clk);
    bus.a         = 32'd200;
    bus.b         = 32'd2;
    @(negedge clk);
    rst           = 1'b1;
    bus.a         = 32'd999;
    bus.b         = 32'd0;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk1("mid.out_valid", bus.out_valid, 1'b0);
    chk ("mid.sum",       bus.sum,       32'h0);
    chk1("mid.cout",      bus.cout,      1'b0);
    chk1("mid.of",        bus.of,        1'b0);
    chk1("mid.zero",      bus.zero,      1'b0);
    chk1("mid.in_ready",  bus.in_ready,  1'b1);
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!bus.out_valid) quiet++;
    end
    chk("mid.no_stale", quiet, 32'd4);
    op_check("post_rst", 32'd40, 32'd2, 1'b0, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
